// File: rtl/joy_db15_responder_if.sv
// DB15 adapter pin bundle: the host drives the load/clock strobes and the device returns serial data.
interface joy_db15_responder_if;
  logic joy_load;
  logic joy_clk;
  logic joy_data;

  modport master (output joy_load, output joy_clk, input joy_data);
  modport slave  (input joy_load, input joy_clk, output joy_data);
endinterface

// File: rtl/joy_db15_responder.sv
// Device-side 74HC165-style shift chain answering a DB15 joystick host reader.
// Optional JOY_DB15_RESP_FILTER_EN adds a 3-sample agreement glitch filter on both strobes.
module joy_db15_responder #(
  parameter int   NBITS  = 32,
  parameter logic SER_IN = 1'b1
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [15:0]                joystick1,
  input  logic [15:0]                joystick2,
  joy_db15_responder_if.slave        jb,
  output logic                       frame_done,
  output logic [5:0]                 bit_cnt
);

  localparam logic [5:0] CNT_MAX = 6'(NBITS);

  // Strobe vectors: bit0 = joy_load, bit1 = joy_clk.
  logic [1:0] pin_s1;
  logic [1:0] pin_s2;
  logic [1:0] lvl;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pin_s1 <= 2'b11;
      pin_s2 <= 2'b11;
    end else begin
      pin_s1 <= {jb.joy_clk, jb.joy_load};
      pin_s2 <= pin_s1;
    end
  end

`ifdef JOY_DB15_RESP_FILTER_EN
  logic [1:0] hist0;
  logic [1:0] hist1;
  logic [1:0] filt_q;
  logic [1:0] agree;

  // The current synced sample plus two older ones must match before the level moves.
  assign agree = ~(pin_s2 ^ hist0) & ~(hist0 ^ hist1);
  assign lvl   = (agree & pin_s2) | (~agree & filt_q);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hist0  <= 2'b11;
      hist1  <= 2'b11;
      filt_q <= 2'b11;
    end else begin
      hist0  <= pin_s2;
      hist1  <= hist0;
      filt_q <= lvl;
    end
  end
`else
  assign lvl = pin_s2;
`endif

  logic clk_prev;
  logic load_act;
  logic shift_act;

  assign load_act  = ~lvl[0];
  assign shift_act = lvl[0] & lvl[1] & ~clk_prev;

  logic [31:0]      load_word;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] shreg_next;
  logic [5:0]       cnt_next;
  logic             fd_next;

  assign load_word = ~{joystick2, joystick1};

  always_comb begin
    shreg_next = shreg;
    cnt_next   = bit_cnt;
    fd_next    = 1'b0;
    if (load_act) begin
      shreg_next = load_word[NBITS-1:0];
      cnt_next   = '0;
    end else if (shift_act) begin
      shreg_next = {SER_IN, shreg[NBITS-1:1]};
      // Counter saturates so surplus host clocks never produce a second pulse.
      if (bit_cnt != CNT_MAX) begin
        cnt_next = bit_cnt + 6'd1;
        fd_next  = (bit_cnt == CNT_MAX - 6'd1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_prev    <= 1'b1;
      shreg       <= '1;
      bit_cnt     <= '0;
      frame_done  <= 1'b0;
      jb.joy_data <= 1'b1;
    end else begin
      clk_prev    <= lvl[1];
      shreg       <= shreg_next;
      bit_cnt     <= cnt_next;
      frame_done  <= fd_next;
      jb.joy_data <= shreg[0];
    end
  end

endmodule

// File: tb/tb_joy_db15_responder.sv
// Directed + randomized bench for joy_db15_responder against a bit-list reference model.
module tb_joy_db15_responder;

  localparam int   NBITS  = 32;
  localparam logic SER_IN = 1'b1;
  localparam int   PH     = 6;
`ifdef JOY_DB15_RESP_FILTER_EN
  localparam int   LAT    = 6;
`else
  localparam int   LAT    = 4;
`endif

  // ---------------- clock / reset ----------------
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;
  logic [5:0]  bit_cnt;

  always #5 clk_sys = ~clk_sys;

  joy_db15_responder_if jb();

  joy_db15_responder #(.NBITS(NBITS), .SER_IN(SER_IN)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .jb         (jb),
    .frame_done (frame_done),
    .bit_cnt    (bit_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  logic       cur_exp;
  int         nshift;
  int         exp_fd  = 0;
  int         fd_seen = 0;
  int         total   = 0;
  int         bad     = 0;

  always @(negedge clk_sys) if (frame_done === 1'b1) fd_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Host sees bit k of the chain on the k-th read: j1 bits first, then j2, then SER_IN forever.
  function automatic logic ref_bit(input logic [15:0] j1, input logic [15:0] j2, input int k);
    if (k < 16)    return ~j1[k];
    if (k < NBITS) return ~j2[k-16];
    return SER_IN;
  endfunction

  task automatic model_load(input logic [15:0] j1, input logic [15:0] j2);
    exp_q.delete();
    cur_exp = ref_bit(j1, j2, 0);
    for (int k = 1; k < NBITS; k++) exp_q.push_back(ref_bit(j1, j2, k));
    nshift = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_exp = 1'b1;
    for (int k = 1; k < NBITS; k++) exp_q.push_back(1'b1);
    nshift = 0;
  endtask

  task automatic model_shift();
    cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : SER_IN;
    if (nshift < NBITS) begin
      nshift++;
      if (nshift == NBITS) exp_fd++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic host_load(input logic [15:0] j1, input logic [15:0] j2);
    joystick1   = j1;
    joystick2   = j2;
    jb.joy_load = 1'b0;
    wait_cyc(PH);
    jb.joy_load = 1'b1;
    wait_cyc(PH);
    model_load(j1, j2);
    chk("load_data", {31'd0, jb.joy_data}, {31'd0, cur_exp});
    chk("load_cnt", {26'd0, bit_cnt}, 32'd0);
  endtask

  task automatic host_clk(input bit lat);
    logic old_v;
    old_v = cur_exp;
    model_shift();
    jb.joy_clk = 1'b1;
    if (lat) begin
      for (int c = 1; c <= LAT; c++) begin
        wait_cyc(1);
        chk("latency", {31'd0, jb.joy_data}, {31'd0, (c < LAT) ? old_v : cur_exp});
      end
    end else begin
      wait_cyc(LAT);
    end
    wait_cyc(PH - LAT);
    chk("shift_data", {31'd0, jb.joy_data}, {31'd0, cur_exp});
    chk("shift_cnt", {26'd0, bit_cnt}, nshift);
    jb.joy_clk = 1'b0;
    wait_cyc(PH);
  endtask

  task automatic run_frame(input logic [15:0] j1, input logic [15:0] j2, input bit scramble);
    host_load(j1, j2);
    for (int k = 0; k < NBITS; k++) begin
      if (scramble) begin
        joystick1 = 16'($urandom);
        joystick2 = 16'($urandom);
      end
      host_clk(1'b0);
    end
    chk("frame_fd", fd_seen, exp_fd);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    jb.joy_load = 1'b1;
    jb.joy_clk  = 1'b0;
    joystick1   = 16'h0000;
    joystick2   = 16'h0000;
    model_reset();

    // Reset held 3 cycles, then idle with no load.
    wait_cyc(3);
    chk("rst_data", {31'd0, jb.joy_data}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_cyc(1);
      chk("idle_data", {31'd0, jb.joy_data}, 32'd1);
      chk("idle_cnt", {26'd0, bit_cnt}, 32'd0);
      chk("idle_fd", {31'd0, frame_done}, 32'd0);
    end

    // Directed frame; first clock verifies pin-to-data latency.
    host_load(16'h0011, 16'h8000);
    chk("t2_bit0", {31'd0, jb.joy_data}, 32'd0);
    host_clk(1'b1);
    for (int k = 1; k < NBITS - 1; k++) host_clk(1'b0);
    chk("t2_fd_early", fd_seen, exp_fd);
    chk("t2_bit31", {31'd0, jb.joy_data}, 32'd0);
    host_clk(1'b0);
    chk("t2_fd_once", fd_seen, exp_fd);
    chk("t2_cnt", {26'd0, bit_cnt}, 32'd32);

    // Surplus clocks: SER_IN out, counter parked, no pulse.
    for (int k = 0; k < 5; k++) host_clk(1'b0);
    chk("t3_data", {31'd0, jb.joy_data}, {31'd0, SER_IN});
    chk("t3_cnt", {26'd0, bit_cnt}, 32'd32);
    chk("t3_fd", fd_seen, exp_fd);

    // Load held low across clock edges while joystick1 changes.
    joystick1   = 16'h0001;
    jb.joy_load = 1'b0;
    wait_cyc(PH);
    chk("t4_data0", {31'd0, jb.joy_data}, 32'd0);
    chk("t4_cnt0", {26'd0, bit_cnt}, 32'd0);
    jb.joy_clk = 1'b1; wait_cyc(PH);
    jb.joy_clk = 1'b0; joystick1 = 16'h0002; wait_cyc(PH);
    chk("t4_data1", {31'd0, jb.joy_data}, 32'd1);
    jb.joy_clk = 1'b1; wait_cyc(PH);
    jb.joy_clk = 1'b0; wait_cyc(PH);
    jb.joy_clk = 1'b1; wait_cyc(PH);
    chk("t4_cnt1", {26'd0, bit_cnt}, 32'd0);
    chk("t4_data2", {31'd0, jb.joy_data}, 32'd1);
    jb.joy_clk = 1'b0; wait_cyc(PH);
    jb.joy_load = 1'b1; wait_cyc(PH);
    model_load(joystick1, joystick2);
    chk("t4_rel_data", {31'd0, jb.joy_data}, {31'd0, cur_exp});
    host_clk(1'b0);

    // Reset mid-frame abandons the frame.
    host_load(16'($urandom), 16'($urandom));
    for (int k = 0; k < 10; k++) host_clk(1'b0);
    reset = 1'b1;
    wait_cyc(1);
    chk("t5_data", {31'd0, jb.joy_data}, 32'd1);
    chk("t5_cnt", {26'd0, bit_cnt}, 32'd0);
    chk("t5_fd", {31'd0, frame_done}, 32'd0);
    wait_cyc(1);
    reset = 1'b0;
    model_reset();
    wait_cyc(4);
    chk("t5_fd_none", fd_seen, exp_fd);
    run_frame(16'($urandom), 16'($urandom), 1'b0);

    // Short joy_clk pulse: filtered build rejects it, plain build shifts once.
    host_load(16'($urandom), 16'($urandom));
`ifdef JOY_DB15_RESP_FILTER_EN
    jb.joy_clk = 1'b1; wait_cyc(1);
    jb.joy_clk = 1'b0;
`else
    jb.joy_clk = 1'b1; wait_cyc(2);
    jb.joy_clk = 1'b0;
    model_shift();
`endif
    wait_cyc(10);
    chk("t6_cnt", {26'd0, bit_cnt}, nshift);
    chk("t6_data", {31'd0, jb.joy_data}, {31'd0, cur_exp});

    // Randomized frames with joystick churn mid-frame.
    for (int f = 0; f < 4; f++) run_frame(16'($urandom), 16'($urandom), 1'b1);
    host_clk(1'b0);
    chk("rand_tail_cnt", {26'd0, bit_cnt}, 32'd32);
    chk("rand_tail_fd", fd_seen, exp_fd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
